prog_loader: RTL and testbench

//  Boot-time program loader placed upstream of the CPU's word memory.
//  - Accepts a byte stream over a valid/ready handshake and packs byte pairs into BITS-wide words.
//  - Writes the words into memory at consecutive addresses starting at 0.
//  - Holds the CPU in reset until the whole image is written, then releases it.

---
 rtl/little_cpu_pkg.sv | 23 ++
 rtl/byte_packer.sv | 54 +++++
 rtl/prog_loader.sv | 173 +++++++++++++++++
 tb/tb_prog_loader.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/little_cpu_pkg.sv
// Shared types for the little CPU boot path: loader FSM states and sizing constants.
package little_cpu_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int WORD_BYTES = 2;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    HI,
    LO,
    WRITE,
    CHK,
    DONE,
    ERROR
  } loader_state_t;

  // States in which the loader pulls a byte from the stream.
  function automatic logic is_rx_state(input loader_state_t s);
    return (s == COUNT) || (s == HI) || (s == LO) || (s == CHK);
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Holds the high/low byte registers of the word being assembled and the running
// XOR of every count/data byte accepted since the last clear.
module byte_packer
  import little_cpu_pkg::*;
#(
  parameter int BITS = 8 * WORD_BYTES
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_clr,
  input  logic            i_take_hi,
  input  logic            i_take_lo,
  input  logic            i_take_acc,
  input  logic [7:0]      i_data,
  output logic [BITS-1:0] o_word,
  output logic [7:0]      o_acc
);

  logic [7:0] hi_q, hi_d;
  logic [7:0] lo_q, lo_d;
  logic [7:0] acc_q, acc_d;

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    acc_d = acc_q;
    if (i_clr) begin
      hi_d  = 8'h00;
      lo_d  = 8'h00;
      acc_d = 8'h00;
    end else begin
      if (i_take_hi)  hi_d  = i_data;
      if (i_take_lo)  lo_d  = i_data;
      if (i_take_acc) acc_d = acc_q ^ i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      hi_q  <= 8'h00;
      lo_q  <= 8'h00;
      acc_q <= 8'h00;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      acc_q <= acc_d;
    end
  end

  // High byte arrives first on the stream.
  assign o_word = {hi_q, lo_q};
  assign o_acc  = acc_q;

endmodule

// File: rtl/prog_loader.sv
// Boot loader: packs a byte stream into words, writes them from address 0 and holds
// the CPU in reset until done. Define LOADER_CHECKSUM_EN for a trailing XOR check byte.
module prog_loader
  import little_cpu_pkg::*;
#(
  parameter int BITS   = 8 * WORD_BYTES,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  output logic              o_rx_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [BITS-1:0]   o_mem_data,
  output logic              o_cpu_rst_n,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rx_ready_q, rx_ready_d;
  logic              mem_we_q, mem_we_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              fire;
  logic              restart;
  logic              last_word;
  logic              clr, take_hi, take_lo, take_acc;
  logic [7:0]        chk_acc;

  assign fire = i_rx_valid && rx_ready_q;
  // A count of 0 wraps to all-ones here, which makes the full 2**ADDR_W image end
  // on the top address without the counter ever wrapping.
  assign last_word = (addr_q == (cnt_q - ADDR_W'(1)));

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    clr      = 1'b0;
    take_hi  = 1'b0;
    take_lo  = 1'b0;
    take_acc = 1'b0;
    restart  = 1'b0;
    case (state_q)
      IDLE: restart = i_start;
      COUNT: begin
        if (fire) begin
          cnt_d    = ADDR_W'(i_rx_data);
          take_acc = 1'b1;
          state_d  = HI;
        end
      end
      HI: begin
        if (fire) begin
          take_hi  = 1'b1;
          take_acc = 1'b1;
          state_d  = LO;
        end
      end
      LO: begin
        if (fire) begin
          take_lo  = 1'b1;
          take_acc = 1'b1;
          state_d  = WRITE;
        end
      end
      WRITE: begin
        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = DONE;
`endif
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = HI;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (fire) state_d = (i_rx_data == chk_acc) ? DONE : ERROR;
      end
      ERROR: restart = i_start;
`endif
      DONE: restart = i_start;
      default: state_d = IDLE;
    endcase

    if (restart) begin
      state_d = COUNT;
      addr_d  = '0;
      clr     = 1'b1;
    end

    // Outputs are decoded from the next state so they are registered yet line up with it.
    rx_ready_d  = is_rx_state(state_d);
    mem_we_d    = (state_d == WRITE);
    busy_d      = is_rx_state(state_d) || (state_d == WRITE);
    done_d      = (state_d == DONE);
    cpu_rst_n_d = (state_d == DONE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      rx_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      rx_ready_q  <= rx_ready_d;
      mem_we_q    <= mem_we_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  byte_packer #(
    .BITS(BITS)
  ) u_packer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (clr),
    .i_take_hi (take_hi),
    .i_take_lo (take_lo),
    .i_take_acc(take_acc),
    .i_data    (i_rx_data),
    .o_word    (o_mem_data),
    .o_acc     (chk_acc)
  );

`ifdef LOADER_CHECKSUM_EN
  logic err_q, err_d;

  assign err_d = (state_d == ERROR);

  always_ff @(posedge i_clk) begin
    if (!i_rst) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign o_err = err_q;
`else
  logic unused_chk_acc;

  assign unused_chk_acc = ^chk_acc;
  assign o_err          = 1'b0;
`endif

  assign o_rx_ready  = rx_ready_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = addr_q;
  assign o_cpu_rst_n = cpu_rst_n_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: image-level write scoreboard plus literal spot checks.
module tb_prog_loader;

  localparam int ADDR_W = 8;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_start;
  logic              i_rx_valid;
  logic [7:0]        i_rx_data;
  logic              o_rx_ready;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [15:0]       o_mem_data;
  logic              o_cpu_rst_n;
  logic              o_busy;
  logic              o_done;
  logic              o_err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  img_q[$];
  logic [23:0] exp_q[$];
  logic [23:0] wr_log[$];
  bit          exp_done_next = 1'b0;
  bit          ph = 1'b0;

  always #5 i_clk = ~i_clk;

  prog_loader #(.BITS(16), .ADDR_W(ADDR_W)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_rx_valid (i_rx_valid),
    .i_rx_data  (i_rx_data),
    .o_rx_ready (o_rx_ready),
    .o_mem_we   (o_mem_we),
    .o_mem_addr (o_mem_addr),
    .o_mem_data (o_mem_data),
    .o_cpu_rst_n(o_cpu_rst_n),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Scoreboard: every write must be the next word of the image; done follows the last write.
  always @(negedge i_clk) begin
    logic [23:0] e;
    if (exp_done_next) begin
      check("done_after_last_write", {30'd0, o_done, o_cpu_rst_n}, 32'h3);
      exp_done_next = 1'b0;
    end
    check("cpu_rst_tracks_done", o_cpu_rst_n, o_done);
`ifndef LOADER_CHECKSUM_EN
    check("err_tied_low", o_err, 0);
`endif
    if (i_rst && o_mem_we) begin
      check("ready_low_in_write", o_rx_ready, 0);
      check("busy_in_write", o_busy, 1);
      wr_log.push_back({o_mem_addr, o_mem_data});
      if (exp_q.size() == 0) begin
        fail_now("unexpected_write");
      end else begin
        e = exp_q.pop_front();
        check("write_addr", o_mem_addr, e[23:16]);
        check("write_data", o_mem_data, e[15:0]);
        if (exp_q.size() == 0 && !CHK_ON) exp_done_next = 1'b1;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, o_rx_ready, 0);
    check({tag, "_we"}, o_mem_we, 0);
    check({tag, "_addr"}, o_mem_addr, 0);
    check({tag, "_data"}, o_mem_data, 0);
    check({tag, "_cpu_rst_n"}, o_cpu_rst_n, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_err"}, o_err, 0);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit toggle);
    int t;
    bit acc;
    t = 0;
    acc = 1'b0;
    i_rx_data = b;
    while (!acc && t < 200) begin
      i_rx_valid = toggle ? ph : 1'b1;
      if (toggle) ph = ~ph;
      @(negedge i_clk);
      acc = o_rx_ready && i_rx_valid;
      @(posedge i_clk);
      #1;
      t++;
    end
    i_rx_valid = 1'b0;
    if (!acc) fail_now("byte_accept_timeout");
  endtask

  task automatic start_load(input bit stray);
    bit reload;
    reload = o_done || o_err;
    i_start = 1'b1;
    if (stray) begin
      i_rx_valid = 1'b1;
      i_rx_data  = 8'h77;
    end
    @(posedge i_clk);
    #1;
    i_start    = 1'b0;
    i_rx_valid = 1'b0;
    @(negedge i_clk);
    check("start_cpu_rst_n", o_cpu_rst_n, 0);
    check("start_busy", o_busy, 1);
    check("start_ready", o_rx_ready, 1);
    if (reload) check("reload_done_cleared", o_done, 0);
    @(posedge i_clk);
    #1;
  endtask

  // Expected writes come straight from the image: word i = {byte[1+2i], byte[2+2i]} at addr i.
  task automatic send_image(input bit toggle, input bit add_chk);
    int n;
    logic [7:0] x;
    n = (img_q[0] == 8'h00) ? 256 : int'(img_q[0]);
    exp_q.delete();
    wr_log.delete();
    for (int i = 0; i < n; i++) exp_q.push_back({8'(i), img_q[1 + 2 * i], img_q[2 + 2 * i]});
    if (add_chk && CHK_ON) begin
      x = 8'h00;
      foreach (img_q[k]) x = x ^ img_q[k];
      img_q.push_back(x);
    end
    for (int idx = 0; idx < img_q.size(); idx++) begin
      send_byte(img_q[idx], toggle);
      if (idx >= 2 && idx <= 2 * n && idx % 2 == 0) begin
        @(negedge i_clk);
        check("we_one_cycle_after_lo", o_mem_we, 1);
        check("ready_low_during_write", o_rx_ready, 0);
        @(posedge i_clk);
        #1;
      end
    end
  endtask

  task automatic wait_end();
    int t;
    t = 0;
    while (!(o_done || o_err) && t < 100) begin
      @(negedge i_clk);
      t++;
    end
    if (!(o_done || o_err)) fail_now("end_of_load_timeout");
    check("all_words_written", exp_q.size(), 0);
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst      = 1'b0;
    i_start    = 1'b0;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
    repeat (3) @(posedge i_clk);
    #1;
    @(negedge i_clk);
    check_all_zero("reset");
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(negedge i_clk);
    check("idle_cpu_rst_n", o_cpu_rst_n, 0);
    check("idle_ready", o_rx_ready, 0);
    @(posedge i_clk);
    #1;

    // Reset mid-stream, right after the HI byte of word 1
    start_load(1'b0);
    exp_q = '{24'h001122, 24'h013344};
    wr_log.delete();
    send_byte(8'h02, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    @(negedge i_clk);
    @(posedge i_clk);
    #1;
    send_byte(8'h33, 1'b0);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    @(negedge i_clk);
    check_all_zero("midstream_reset");
    exp_q.delete();
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;

    // Fresh load from IDLE with a stray byte offered alongside start
    start_load(1'b1);
    img_q = '{8'h01, 8'h56, 8'h78};
    send_image(1'b0, 1'b1);
    wait_end();
    check("fresh_count", wr_log.size(), 1);
    check("fresh_word0", wr_log[0], 24'h005678);

    // Basic two-word load
    start_load(1'b0);
    img_q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    send_image(1'b0, 1'b1);
    wait_end();
    check("basic_word0", wr_log[0], 24'h001234);
    check("basic_word1", wr_log[1], 24'h01ABCD);
    check("basic_done", o_done, 1);
    check("basic_cpu_rst_n", o_cpu_rst_n, 1);
    check("basic_ready_in_done", o_rx_ready, 0);

    // Back-pressure: valid toggling every cycle
    start_load(1'b0);
    img_q = '{8'h03, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    send_image(1'b1, 1'b1);
    wait_end();
    check("bp_count", wr_log.size(), 3);
    check("bp_word1", wr_log[1], 24'h01C3D4);
    check("bp_word2", wr_log[2], 24'h02E5F6);

    // Count 0 means a full 256-word image
    start_load(1'b0);
    img_q = '{8'h00};
    for (int i = 0; i < 256; i++) begin
      img_q.push_back(8'(i));
      img_q.push_back(~8'(i));
    end
    send_image(1'b0, 1'b1);
    wait_end();
    check("full_count", wr_log.size(), 256);
    check("full_last", wr_log[255], 24'hFFFF00);
    check("full_done", o_done, 1);

`ifdef LOADER_CHECKSUM_EN
    start_load(1'b0);
    img_q = '{8'h01, 8'h55, 8'hAA, 8'hFE};
    send_image(1'b0, 1'b0);
    wait_end();
    check("chk_good_done", o_done, 1);
    check("chk_good_err", o_err, 0);
    check("chk_good_word", wr_log[0], 24'h0055AA);

    start_load(1'b0);
    img_q = '{8'h01, 8'h55, 8'hAA, 8'h00};
    send_image(1'b0, 1'b0);
    wait_end();
    repeat (3) begin
      @(negedge i_clk);
      check("chk_bad_err", o_err, 1);
      check("chk_bad_cpu_rst_n", o_cpu_rst_n, 0);
      check("chk_bad_done", o_done, 0);
      check("chk_bad_ready", o_rx_ready, 0);
    end
    @(posedge i_clk);
    #1;

    start_load(1'b0);
    check("chk_recover_err_cleared", o_err, 0);
    img_q = '{8'h01, 8'h55, 8'hAA, 8'hFE};
    send_image(1'b0, 1'b0);
    wait_end();
    check("chk_recover_done", o_done, 1);
`else
    start_load(1'b0);
    img_q = '{8'h01, 8'h55, 8'hAA};
    send_image(1'b0, 1'b0);
    wait_end();
    check("nochk_done", o_done, 1);
    check("nochk_err", o_err, 0);
`endif

    // Reload from DONE overwrites from address 0
    start_load(1'b0);
    img_q = '{8'h02, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    send_image(1'b0, 1'b1);
    wait_end();
    check("reload_word0", wr_log[0], 24'h009ABC);
    check("reload_word1", wr_log[1], 24'h01DEF0);
    check("reload_done", o_done, 1);

    repeat (2) @(posedge i_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
